// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings and
// operand-forward select codes.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;
  localparam logic [7:0]  WD_LIMIT      = 8'd255;

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Forward-select compare for one EX operand; a load in EX cannot forward
// because its data is not yet available.
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [2:0] src,
  input  logic [2:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [2:0] mem_rd,
  input  logic       mem_regwrite,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (ex_regwrite && !ex_memread && (src == ex_rd)) begin
      sel = FWD_EX;
    end else if (mem_regwrite && (src == mem_rd)) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush decode, registered operand
// forwarding selects, stall counter and data-memory watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [2:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [2:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic        ex_redirect,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [15:0] stall_cnt,
  output logic        err
);

  state_e      state_q, state_d;
  logic [1:0]  fwd_a_q, fwd_b_q;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt_q;
  logic [7:0]  wd_cnt_q;
  logic        err_q;
  logic        load_use;
  logic        pc_we_dec, ifid_we_dec, idex_we_dec, exmem_we_dec;
  logic        ifid_flush_dec, idex_bubble_dec;

  fwd_sel u_fwd_a (
    .src          (id_rs),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .sel          (fwd_a_sel)
  );

  fwd_sel u_fwd_b (
    .src          (id_rt),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .sel          (fwd_b_sel)
  );

  assign load_use = ex_memread & ex_regwrite &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  // MEMWAIT with the stall released evaluates exactly like RUN.
  always_comb begin
    state_d         = RUN;
    pc_we_dec       = 1'b1;
    ifid_we_dec     = 1'b1;
    idex_we_dec     = 1'b1;
    exmem_we_dec    = 1'b1;
    ifid_flush_dec  = 1'b0;
    idex_bubble_dec = 1'b0;
    if (dmem_stall) begin
      pc_we_dec    = 1'b0;
      ifid_we_dec  = 1'b0;
      idex_we_dec  = 1'b0;
      exmem_we_dec = 1'b0;
      state_d      = MEMWAIT;
    end else if (state_q == FLUSH) begin
      if (imem_stall) begin
        pc_we_dec      = 1'b0;
        ifid_flush_dec = 1'b1;
      end
    end else if (ex_redirect) begin
      ifid_flush_dec  = 1'b1;
      idex_bubble_dec = 1'b1;
      state_d         = FLUSH;
    end else if (load_use) begin
      pc_we_dec       = 1'b0;
      ifid_we_dec     = 1'b0;
      idex_bubble_dec = 1'b1;
    end else if (imem_stall) begin
      pc_we_dec      = 1'b0;
      ifid_flush_dec = 1'b1;
    end
  end

  // Enables read as 1 while reset is held, whatever the inputs are doing.
  assign pc_we       = ~rst | pc_we_dec;
  assign ifid_we     = ~rst | ifid_we_dec;
  assign idex_we     = ~rst | idex_we_dec;
  assign exmem_we    = ~rst | exmem_we_dec;
  assign ifid_flush  = rst & ifid_flush_dec;
  assign idex_bubble = rst & idex_bubble_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= 16'd0;
      wd_cnt_q    <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (idex_we) begin
        fwd_a_q <= idex_bubble ? FWD_RF : fwd_a_sel;
        fwd_b_q <= idex_bubble ? FWD_RF : fwd_b_sel;
      end
      if (!pc_we && (stall_cnt_q != STALL_CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (state_q == MEMWAIT) begin
        if (wd_cnt_q != WD_LIMIT) begin
          wd_cnt_q <= wd_cnt_q + 8'd1;
        end
        if (wd_cnt_q == WD_LIMIT - 8'd1) begin
          err_q <= 1'b1;
        end
      end else begin
        wd_cnt_q <= 8'd0;
      end
    end
  end

  assign forwardA  = fwd_a_q;
  assign forwardB  = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite;
  logic        ex_redirect, imem_stall, dmem_stall;
  logic [1:0]  forwardA, forwardB;
  logic        pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble;
  logic [15:0] stall_cnt;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .ex_redirect  (ex_redirect),
    .imem_stall   (imem_stall),
    .dmem_stall   (dmem_stall),
    .forwardA     (forwardA),
    .forwardB     (forwardB),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .idex_we      (idex_we),
    .exmem_we     (exmem_we),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .stall_cnt    (stall_cnt),
    .err          (err)
  );

  wire [3:0] en = {pc_we, ifid_we, idex_we, exmem_we};
  wire [1:0] fb = {ifid_flush, idex_bubble};
  wire [1:0] st = dut.state_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("check %s: got %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 3'd0; id_rt = 3'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rd = 3'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 3'd0; mem_regwrite = 1'b0;
    ex_redirect = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
  endtask

  initial begin
    clr();
    rst = 1'b0;
    dmem_stall = 1'b1;
    #2;
    check_eq("rst_en", en, 4'hF);
    check_eq("rst_fb", fb, 2'b00);
    check_eq("rst_fwdA", forwardA, 2'b00);
    check_eq("rst_stall_cnt", stall_cnt, 16'd0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_state", st, 2'd0);
    step(); step();
    dmem_stall = 1'b0;
    rst = 1'b1;

    // ALU forward from EX, EX beats MEM on the same register
    ex_rd = 3'd3; ex_regwrite = 1'b1; mem_rd = 3'd3; mem_regwrite = 1'b1;
    id_rs = 3'd3; id_rt = 3'd0; id_use_rs = 1'b1;
    #1 check_eq("alu_en", en, 4'hF);
    step();
    check_eq("alu_fwdA", forwardA, 2'b10);
    check_eq("alu_fwdB", forwardB, 2'b00);
    // register 0 forwards from MEM like any other
    mem_rd = 3'd0;
    step();
    check_eq("r0_fwdA", forwardA, 2'b10);
    check_eq("r0_fwdB", forwardB, 2'b01);
    // load in EX is not an EX forward; no use flags means no load-use
    ex_memread = 1'b1; mem_rd = 3'd3; id_use_rs = 1'b0;
    #1 check_eq("ld_nouse_en", en, 4'hF);
    step();
    check_eq("ld_nouse_fwdA", forwardA, 2'b01);
    check_eq("ld_nouse_fwdB", forwardB, 2'b00);

    // load-use stall then MEM forward
    clr();
    ex_rd = 3'd3; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rt = 3'd3; id_use_rt = 1'b1; id_rs = 3'd5; id_use_rs = 1'b1;
    #1 check_eq("lu_en", en, 4'b0011);
    check_eq("lu_fb", fb, 2'b01);
    step();
    check_eq("lu_fwdA", forwardA, 2'b00);
    check_eq("lu_fwdB", forwardB, 2'b00);
    check_eq("lu_stall_cnt", stall_cnt, 16'd1);
    ex_regwrite = 1'b0; ex_memread = 1'b0; mem_rd = 3'd3; mem_regwrite = 1'b1;
    #1 check_eq("lu2_en", en, 4'hF);
    step();
    check_eq("lu2_fwdB", forwardB, 2'b01);
    check_eq("lu2_fwdA", forwardA, 2'b00);
    check_eq("lu2_stall_cnt", stall_cnt, 16'd1);

    // redirect outranks load-use; FLUSH suppresses load-use for one cycle
    clr();
    ex_rd = 3'd3; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rt = 3'd3; id_use_rt = 1'b1; ex_redirect = 1'b1;
    #1 check_eq("rd_en", en, 4'hF);
    check_eq("rd_fb", fb, 2'b11);
    step();
    check_eq("rd_state", st, 2'd1);
    check_eq("fl_en", en, 4'hF);
    check_eq("fl_fb", fb, 2'b00);
    step();
    check_eq("fl_state", st, 2'd0);
    clr();

    // instruction-memory stall alone
    imem_stall = 1'b1;
    #1 check_eq("im_en", en, 4'b0111);
    check_eq("im_fb", fb, 2'b10);
    step();
    check_eq("im_stall_cnt", stall_cnt, 16'd2);
    clr();

    // data-memory stall for 5 cycles alongside a redirect
    dmem_stall = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check_eq("dm5_en", en, 4'h0);
      check_eq("dm5_fb", fb, 2'b00);
      step();
    end
    dmem_stall = 1'b0;
    #1 check_eq("dm5_rel_en", en, 4'hF);
    check_eq("dm5_rel_fb", fb, 2'b11);
    step();
    check_eq("dm5_state", st, 2'd1);
    check_eq("dm5_stall_cnt", stall_cnt, 16'd7);
    ex_redirect = 1'b0;
    step();
    check_eq("dm5_run", st, 2'd0);

    // watchdog: 300-cycle data stall
    dmem_stall = 1'b1;
    repeat (255) step();
    check_eq("wd_err_254", err, 1'b0);
    step();
    check_eq("wd_err_255", err, 1'b1);
    repeat (44) step();
    dmem_stall = 1'b0;
    #1 check_eq("wd_rel_en", en, 4'hF);
    step();
    check_eq("wd_err_after", err, 1'b1);
    check_eq("wd_stall_cnt", stall_cnt, 16'd307);
    check_eq("wd_state", st, 2'd0);

    // asynchronous reset in the middle of MEMWAIT
    dmem_stall = 1'b1;
    repeat (3) step();
    check_eq("mr_state_pre", st, 2'd2);
    check_eq("mr_stall_pre", stall_cnt, 16'd310);
    #2 rst = 1'b0;
    #1 check_eq("mr_state", st, 2'd0);
    check_eq("mr_stall_cnt", stall_cnt, 16'd0);
    check_eq("mr_err", err, 1'b0);
    check_eq("mr_en", en, 4'hF);
    step();
    check_eq("mr_state_hold", st, 2'd0);
    dmem_stall = 1'b0;
    rst = 1'b1;
    step();
    check_eq("mr_state_post", st, 2'd0);
    check_eq("mr_err_post", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
